conv_norm_out: RTL and testbench
================================

Name: conv_norm_out

Overview:
Downstream stage of the Gaussian convolution core. It takes the 24-bit raw convolution stream (one result per image pixel, raster order, no stall capability), then normalises, rounds, saturates and border-masks each result into an 8-bit pixel. Output is an AXI4-Stream through an elastic FIFO, with SOF/EOL framing. An upstream throttle signal is generated so the non-stallable convolution pipeline never overruns the FIFO.

Parameters:
IMAGE_COLUMN, 512, pixels per row
IMAGE_ROW, 512, rows per frame
IMAGE_DATA_WIDTH, 8, output pixel width
CONV_KERNEL_SIZE, 11, kernel size n (odd); HALF=(n-1)/2 border rows/cols masked
NORM_SHIFT, 16, right shift applied after rounding (kernel gain 2^NORM_SHIFT)
BORDER_VALUE, 0, pixel value emitted in masked border region
FIFO_DEPTH, 16, output FIFO entries (power of 2, >=8)
PIPE_SLACK, 8, free-entry threshold below which s_ready deasserts

Ports:
axi_clk  in  1  clock
axi_rstn  in  1  asynchronous active-low reset
conv_valid  in  1  raw result valid, one pulse per pixel
conv_result  in  24  raw unsigned convolution sum
s_ready  out  1  throttle to pixel source; high = at least PIPE_SLACK FIFO entries free
m_axis_tdata  out  IMAGE_DATA_WIDTH  normalised pixel
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last pixel of row
m_axis_tuser  out  1  first pixel of frame (SOF)
ovf_clr  in  1  clears sticky overflow flag
overflow  out  1  sticky: a result was dropped because the FIFO was full
frame_done  out  1  one-cycle pulse when the last pixel of a frame is written to the FIFO

Behaviour:
- Reset (async assert, sync release): all counters 0, FIFO empty, pipeline valid 0. Outputs: m_axis_tvalid=0, tdata=0, tlast=0, tuser=0, overflow=0, frame_done=0, s_ready=1.
- Stage 1 (conv_valid cycle t, registered at t+1):
  - rnd = conv_result + 2^(NORM_SHIFT-1), computed at 25 bits.
  - q = rnd >> NORM_SHIFT.
  - pix = (q > 2^IMAGE_DATA_WIDTH-1) ? all-ones : q[IMAGE_DATA_WIDTH-1:0].
  - Border mask: if row<HALF, row>IMAGE_ROW-1-HALF, col<HALF or col>IMAGE_COLUMN-1-HALF, then pix=BORDER_VALUE.
  - Tags: tuser=(row==0 && col==0); tlast=(col==IMAGE_COLUMN-1).
- Counters: col/row advance only on conv_valid. col wraps IMAGE_COLUMN-1→0 and increments row. row wraps IMAGE_ROW-1→0 at end of frame. frame_done pulses in the write cycle of pixel (IMAGE_ROW-1, IMAGE_COLUMN-1).
- Stage 2 (t+2): {tuser,tlast,pix} is written into the FIFO.
  - The FIFO is first-word-fall-through, so with the FIFO empty and tready high, m_axis_tvalid rises at t+2. Total latency is 2 clk.
- FIFO read occurs when m_axis_tvalid && m_axis_tready. tdata, tlast and tuser stay stable while tvalid && !tready.
- Write when full:
  - If a read happens in the same cycle, the write is accepted and occupancy is unchanged.
  - Otherwise the word is dropped and overflow is set. Counters still advance, so frame alignment is kept.
- Simultaneous read+write on an empty FIFO: the written word is not visible until the next cycle; the empty FIFO is not bypassed.
- s_ready = (FIFO_DEPTH - occupancy) >= PIPE_SLACK, registered. It is advisory only; this block never stalls its input.
- overflow is cleared by ovf_clr. If a set and a clear occur in the same cycle, set wins.
- Pointers wrap modulo FIFO_DEPTH. full/empty are distinguished with an extra pointer MSB.
- Reset mid-frame discards FIFO contents and in-flight pipeline data; the next conv_valid is treated as pixel (0,0).

Test Plan:
- Rounding/saturation (IMAGE_COLUMN=16, IMAGE_ROW=12, pixel at (5,5)):
  - conv_result 0x007FFF → tdata 0x00
  - 0x008000 → 0x01
  - 0x123456 → 0x12
  - 0xFF7FFF → 0xFF
  - 0xFF8000 → 0xFF (saturated)
- Border mask (same small image, all inputs 0x400000): pixels (0,0), (4,15), (7,11) and (11,7) → 0x00; (5,5) and (6,10) → 0x40. Over the frame, tuser is set only on the first beat and tlast on every 16th beat; frame_done pulses once, 2 cycles after the last conv_valid.
- Latency: single conv_valid at cycle t with tready=1 and FIFO empty → tvalid high at exactly t+2 for one cycle.
- Backpressure:
  - Hold tready=0 and stream 9 results → s_ready falls once 9 entries are held (7 free < PIPE_SLACK). Output data stays stable.
  - Release tready → all 9 emerge in order with no loss; overflow=0.
- Overflow:
  - tready=0 and 20 results into depth 16 → first 16 are retained, overflow=1.
  - Pulse ovf_clr → overflow=0. Drain → 16 beats, and the subsequent frame's tuser is still on pixel (0,0).
- Async reset: assert axi_rstn low mid-row with 5 words queued → tvalid drops immediately and s_ready=1. After release, the next input is tagged tuser=1.

Source files
------------

// File: rtl/conv_norm_out.sv
// Output stage of the Gaussian convolution core: normalise, round, saturate and
// border-mask raw sums, then emit framed pixels through an elastic AXI4-Stream FIFO.
module conv_norm_out #(
    parameter int unsigned IMAGE_COLUMN     = 512,
    parameter int unsigned IMAGE_ROW        = 512,
    parameter int unsigned IMAGE_DATA_WIDTH = 8,
    parameter int unsigned CONV_KERNEL_SIZE = 11,
    parameter int unsigned NORM_SHIFT       = 16,
    parameter int unsigned BORDER_VALUE     = 0,
    parameter int unsigned FIFO_DEPTH       = 16,
    parameter int unsigned PIPE_SLACK       = 8
) (
    input  logic                        axi_clk,
    input  logic                        axi_rstn,
    input  logic                        conv_valid,
    input  logic [23:0]                 conv_result,
    output logic                        s_ready,
    output logic [IMAGE_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tuser,
    input  logic                        ovf_clr,
    output logic                        overflow,
    output logic                        frame_done
);

    localparam int unsigned COL_W   = (IMAGE_COLUMN > 1) ? $clog2(IMAGE_COLUMN) : 1;
    localparam int unsigned ROW_W   = (IMAGE_ROW > 1) ? $clog2(IMAGE_ROW) : 1;
    localparam int unsigned HALF    = (CONV_KERNEL_SIZE - 1) / 2;
    localparam int unsigned RND_W   = 25;
    localparam int unsigned PIX_MAX = (1 << IMAGE_DATA_WIDTH) - 1;
    localparam int unsigned WORD_W  = IMAGE_DATA_WIDTH + 2;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;

    logic [COL_W-1:0]            r_col;
    logic [ROW_W-1:0]            r_row;
    logic                        w_col_last;
    logic                        w_row_last;
    logic [RND_W-1:0]            w_rnd;
    logic [RND_W-1:0]            w_q;
    logic [IMAGE_DATA_WIDTH-1:0] w_pix_sat;
    logic [IMAGE_DATA_WIDTH-1:0] w_pix;
    logic                        w_border;

    logic                        r_s1_valid;
    logic                        r_s1_eof;
    logic [WORD_W-1:0]           r_s1_word;

    logic [WORD_W-1:0]           r_mem [FIFO_DEPTH];
    logic [CNT_W-1:0]            r_wr_ptr;
    logic [CNT_W-1:0]            r_rd_ptr;
    logic [CNT_W-1:0]            w_rd_ptr_nxt;
    logic [CNT_W-1:0]            w_count;
    logic [CNT_W-1:0]            w_count_nxt;
    logic                        w_full;
    logic                        w_rd;
    logic                        w_wr;
    logic                        w_drop;
    logic [WORD_W-1:0]           w_head_nxt;

    logic                        r_tvalid;
    logic [WORD_W-1:0]           r_head;
    logic                        r_s_ready;
    logic                        r_overflow;
    logic                        r_frame_done;

    assign w_col_last = (r_col == COL_W'(IMAGE_COLUMN - 1));
    assign w_row_last = (r_row == ROW_W'(IMAGE_ROW - 1));

    // Round-half-up, shift down by the kernel gain, clamp to pixel range
    assign w_rnd     = RND_W'(conv_result) + (RND_W'(1) << (NORM_SHIFT - 1));
    assign w_q       = w_rnd >> NORM_SHIFT;
    assign w_pix_sat = (w_q > RND_W'(PIX_MAX)) ? '1 : w_q[IMAGE_DATA_WIDTH-1:0];
    assign w_border  = (r_row < ROW_W'(HALF)) || (r_row > ROW_W'(IMAGE_ROW - 1 - HALF)) ||
                       (r_col < COL_W'(HALF)) || (r_col > COL_W'(IMAGE_COLUMN - 1 - HALF));
    assign w_pix     = w_border ? IMAGE_DATA_WIDTH'(BORDER_VALUE) : w_pix_sat;

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            r_col      <= '0;
            r_row      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_eof   <= 1'b0;
            r_s1_word  <= '0;
        end else begin
            r_s1_valid <= conv_valid;
            if (conv_valid) begin
                r_s1_word <= {(r_row == '0) && (r_col == '0), w_col_last, w_pix};
                r_s1_eof  <= w_col_last && w_row_last;
                r_col     <= w_col_last ? '0 : r_col + COL_W'(1);
                if (w_col_last) begin
                    r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
                end
            end
        end
    end

    // A full FIFO still accepts a word when the head is popped in the same cycle
    assign w_count      = r_wr_ptr - r_rd_ptr;
    assign w_full       = (w_count == CNT_W'(FIFO_DEPTH));
    assign w_rd         = r_tvalid && m_axis_tready;
    assign w_wr         = r_s1_valid && (!w_full || w_rd);
    assign w_drop       = r_s1_valid && w_full && !w_rd;
    assign w_count_nxt  = w_count + CNT_W'(w_wr) - CNT_W'(w_rd);
    assign w_rd_ptr_nxt = r_rd_ptr + CNT_W'(w_rd);

    // Registered head: forward the incoming word when it lands in the next head slot
    always_comb begin
        w_head_nxt = r_mem[w_rd_ptr_nxt[PTR_W-1:0]];
        if (w_wr && (r_wr_ptr[PTR_W-1:0] == w_rd_ptr_nxt[PTR_W-1:0])) begin
            w_head_nxt = r_s1_word;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_tvalid     <= 1'b0;
            r_head       <= '0;
            r_s_ready    <= 1'b1;
            r_overflow   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr[PTR_W-1:0]] <= r_s1_word;
                r_wr_ptr                   <= r_wr_ptr + CNT_W'(1);
            end
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_tvalid     <= (w_count_nxt != '0);
            r_head       <= w_head_nxt;
            r_s_ready    <= (CNT_W'(FIFO_DEPTH) - w_count_nxt) >= CNT_W'(PIPE_SLACK);
            r_frame_done <= r_s1_valid && r_s1_eof;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign s_ready       = r_s_ready;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tuser  = r_head[WORD_W-1];
    assign m_axis_tlast  = r_head[WORD_W-2];
    assign m_axis_tdata  = r_head[IMAGE_DATA_WIDTH-1:0];
    assign overflow      = r_overflow;
    assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_conv_norm_out.sv
// Scoreboard bench for conv_norm_out on a 16x12 image: an arithmetic reference model
// queues expected beats at drive time, a negedge monitor pops and compares them.
module tb_conv_norm_out;

    localparam int COLS  = 16;
    localparam int ROWS  = 12;
    localparam int HALF  = 5;
    localparam int DEPTH = 16;

    logic        axi_clk;
    logic        axi_rstn;
    logic        conv_valid;
    logic [23:0] conv_result;
    logic        s_ready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        ovf_clr;
    logic        overflow;
    logic        frame_done;

    conv_norm_out #(
        .IMAGE_COLUMN    (COLS),
        .IMAGE_ROW       (ROWS),
        .IMAGE_DATA_WIDTH(8),
        .CONV_KERNEL_SIZE(11),
        .NORM_SHIFT      (16),
        .BORDER_VALUE    (0),
        .FIFO_DEPTH      (DEPTH),
        .PIPE_SLACK      (8)
    ) u_dut (
        .axi_clk      (axi_clk),
        .axi_rstn     (axi_rstn),
        .conv_valid   (conv_valid),
        .conv_result  (conv_result),
        .s_ready      (s_ready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .ovf_clr      (ovf_clr),
        .overflow     (overflow),
        .frame_done   (frame_done)
    );

    initial begin
        axi_clk = 1'b0;
        forever #5 axi_clk = ~axi_clk;
    end

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         last_cyc = 0;
    int         fd_count = 0;
    int         fd_cyc   = -1;
    int         beat_cnt = 0;
    int         m_row    = 0;
    int         m_col    = 0;
    logic [9:0] sb [$];
    logic [9:0] exp_w;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: {tuser, tlast, pixel} for a raw sum at (r, c)
    function automatic logic [9:0] model(input int r, input int c, input logic [23:0] d);
        int q;
        q = (int'(d) + 32768) / 65536;
        if (q > 255) q = 255;
        if (r < HALF || r > ROWS - 1 - HALF || c < HALF || c > COLS - 1 - HALF) q = 0;
        return {(r == 0 && c == 0), (c == COLS - 1), 8'(q)};
    endfunction

    always @(posedge axi_clk) cyc <= cyc + 1;

    always @(negedge axi_clk) begin
        if (frame_done) begin
            fd_count++;
            fd_cyc = cyc;
        end
        if (m_axis_tvalid && m_axis_tready) begin
            beat_cnt++;
            if (sb.size() == 0) begin
                check("extra_beat", {31'b0, m_axis_tvalid}, 32'd0);
            end else begin
                exp_w = sb.pop_front();
                check("tdata", {24'b0, m_axis_tdata}, {24'b0, exp_w[7:0]});
                check("tlast", {31'b0, m_axis_tlast}, {31'b0, exp_w[8]});
                check("tuser", {31'b0, m_axis_tuser}, {31'b0, exp_w[9]});
            end
        end
    end

    // drop_ok: tready is held low, so words beyond DEPTH are expected to be lost
    task automatic drive_pix(input logic [23:0] d, input bit drop_ok);
        @(posedge axi_clk);
        #1;
        conv_valid  = 1'b1;
        conv_result = d;
        if (!drop_ok || sb.size() < DEPTH) sb.push_back(model(m_row, m_col, d));
        last_cyc = cyc;
        if (m_col == COLS - 1) begin
            m_col = 0;
            m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
    endtask

    task automatic idle(input int n);
        @(posedge axi_clk);
        #1;
        conv_valid = 1'b0;
        repeat (n) @(posedge axi_clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge axi_clk);
        #1;
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    logic [23:0] rnd_tbl [5];
    int          b0;

    initial begin
        rnd_tbl[0] = 24'h007FFF;
        rnd_tbl[1] = 24'h008000;
        rnd_tbl[2] = 24'h123456;
        rnd_tbl[3] = 24'hFF7FFF;
        rnd_tbl[4] = 24'hFF8000;
        axi_rstn      = 1'b0;
        conv_valid    = 1'b0;
        conv_result   = '0;
        m_axis_tready = 1'b1;
        ovf_clr       = 1'b0;

        repeat (2) @(negedge axi_clk);
        check("rst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
        check("rst_tdata", {24'b0, m_axis_tdata}, 32'd0);
        check("rst_tlast", {31'b0, m_axis_tlast}, 32'd0);
        check("rst_tuser", {31'b0, m_axis_tuser}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        check("rst_frame_done", {31'b0, frame_done}, 32'd0);
        check("rst_s_ready", {31'b0, s_ready}, 32'd1);
        @(posedge axi_clk);
        #3 axi_rstn = 1'b1;

        // Frame 1: rounding/saturation cases at (5,5..9), random elsewhere
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (r == 5 && c >= 5 && c <= 9) drive_pix(rnd_tbl[c-5], 1'b0);
                else drive_pix(24'($urandom()), 1'b0);
            end
        end
        idle(4);
        wait_drain("drain_frame1");
        check("fd_count_1", 32'(fd_count), 32'd1);

        // Frame 2: flat 0x400000 exercises the border mask and framing tags
        for (int p = 0; p < ROWS * COLS; p++) drive_pix(24'h400000, 1'b0);
        idle(4);
        wait_drain("drain_frame2");
        check("fd_count_2", 32'(fd_count), 32'd2);
        check("fd_latency", 32'(fd_cyc), 32'(last_cyc + 2));

        // Latency: one pixel into an empty FIFO
        drive_pix(24'h400000, 1'b0);
        b0 = last_cyc;
        @(negedge axi_clk);
        check("lat_t0", {31'b0, m_axis_tvalid}, 32'd0);
        @(posedge axi_clk);
        #1 conv_valid = 1'b0;
        @(negedge axi_clk);
        check("lat_t1", {31'b0, m_axis_tvalid}, 32'd0);
        @(negedge axi_clk);
        check("lat_t2", {31'b0, m_axis_tvalid}, 32'd1);
        check("lat_cycle", 32'(cyc), 32'(b0 + 2));
        @(negedge axi_clk);
        check("lat_t3", {31'b0, m_axis_tvalid}, 32'd0);
        idle(2);

        // Backpressure: s_ready threshold between 8 and 9 held entries
        m_axis_tready = 1'b0;
        for (int i = 0; i < 8; i++) drive_pix(24'($urandom()), 1'b0);
        idle(3);
        check("bp_sready_8", {31'b0, s_ready}, 32'd1);
        drive_pix(24'($urandom()), 1'b0);
        idle(3);
        check("bp_sready_9", {31'b0, s_ready}, 32'd0);
        check("bp_tvalid", {31'b0, m_axis_tvalid}, 32'd1);
        exp_w = sb[0];
        check("bp_hold_a", {22'b0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {22'b0, exp_w});
        idle(4);
        check("bp_hold_b", {22'b0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {22'b0, exp_w});
        m_axis_tready = 1'b1;
        wait_drain("bp_drain");
        idle(2);
        check("bp_overflow", {31'b0, overflow}, 32'd0);
        check("bp_sready_after", {31'b0, s_ready}, 32'd1);

        // Overflow: 20 words into a 16-deep FIFO with no reads
        m_axis_tready = 1'b0;
        for (int i = 0; i < 20; i++) drive_pix(24'($urandom()), 1'b1);
        idle(4);
        check("ovf_set", {31'b0, overflow}, 32'd1);
        check("ovf_sb_depth", 32'(sb.size()), 32'(DEPTH));
        check("ovf_sready", {31'b0, s_ready}, 32'd0);
        @(posedge axi_clk);
        #1 ovf_clr = 1'b1;
        @(posedge axi_clk);
        #1 ovf_clr = 1'b0;
        @(negedge axi_clk);
        check("ovf_clr", {31'b0, overflow}, 32'd0);
        b0 = beat_cnt;
        m_axis_tready = 1'b1;
        wait_drain("ovf_drain");
        check("ovf_beats", 32'(beat_cnt - b0), 32'(DEPTH));
        while (!(m_row == 0 && m_col == 0)) drive_pix(24'($urandom()), 1'b0);
        for (int i = 0; i < 3; i++) drive_pix(24'($urandom()), 1'b0);
        idle(3);
        wait_drain("realign_drain");

        // Async reset mid-row with 5 words queued
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) drive_pix(24'h400000, 1'b0);
        idle(3);
        @(negedge axi_clk);
        check("prerst_tvalid", {31'b0, m_axis_tvalid}, 32'd1);
        #1 axi_rstn = 1'b0;
        #1;
        check("arst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
        check("arst_sready", {31'b0, s_ready}, 32'd1);
        sb.delete();
        m_row = 0;
        m_col = 0;
        @(posedge axi_clk);
        #3 axi_rstn = 1'b1;
        m_axis_tready = 1'b1;
        drive_pix(24'h123456, 1'b0);
        idle(4);
        wait_drain("arst_drain");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
